muldiv_unit: RTL and testbench

Parametrised RV M-extension multiply/divide execution unit; successor to the fixed 32-bit unit. It adds XLEN generalisation, a configurable multiplier latency, and valid/ready request and response handshakes with a pass-through tag. It also adds pipeline flush and full RISC-V corner-case semantics (divide-by-zero, signed overflow). It sits beside the ALU in EX and holds one operation in flight.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_div_core.sv | 93 +++++++++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV M-extension multiply/divide unit: funct3 codes,
// FSM states and the operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  // rs1 is treated as signed for every op except MULHU, DIVU and REMU
  function automatic logic opSignedA(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic opSignedB(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle of the multiply/divide unit, including the
// pipeline flush from the EX stage.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// With MULDIV_EARLY_OUT_EN the dividend is pre-shifted past its leading zeros.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] loadDividend;
  logic [CW-1:0]   loadCount;

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [CW-1:0] countLeadingZeros(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + CW'(1);
      else                 found = 1'b1;
    end
    return n;
  endfunction

  logic [CW-1:0] leadZeros;

  always_comb begin
    leadZeros    = countLeadingZeros(dividend_i);
    loadDividend = dividend_i << leadZeros;
    loadCount    = CW'(XLEN) - leadZeros;
  end
`else
  always_comb begin
    loadDividend = dividend_i;
    loadCount    = CW'(XLEN);
  end
`endif

  // The dividend shifts out of quo_q's top while quotient bits shift in at the bottom
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, div_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= loadDividend;
      rem_q  <= '0;
      div_q  <= divisor_i;
      cnt_q  <= loadCount;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
        rem_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit with valid/ready handshakes, tag echo and flush.
// Optional MULDIV_EARLY_OUT_EN shortens divides by skipping leading dividend zeros.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int              PIPE_N  = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             signA_q, signB_q;
  logic [XLEN-1:0]  resData_q, resData_d;
  logic [2:0]       mulCnt_q, mulCnt_d;

  logic             accept, divStart, divDone, divSpecial, signedDivQ;
  logic [2*XLEN-1:0] mulA, mulB, product;
  logic [XLEN-1:0]  mulResult, mulTail, absA, absB, specialResult;
  logic [XLEN-1:0]  divQuo, divRem, quoFixed, remFixed, divResult;

  assign bus.req_ready = (state_q == IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // Sign-extending to 2*XLEN gives the same low 2*XLEN product bits as an XLEN+1 extension
  always_comb begin
    mulA      = {{XLEN{opSignedA(bus.req_op) & bus.req_a[XLEN-1]}}, bus.req_a};
    mulB      = {{XLEN{opSignedB(bus.req_op) & bus.req_b[XLEN-1]}}, bus.req_b};
    product   = mulA * mulB;
    mulResult = (bus.req_op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  if (MUL_STAGES > 1) begin : gMulPipe
    logic [XLEN-1:0] mulPipe_q [PIPE_N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_N; i++) mulPipe_q[i] <= '0;
      end else begin
        if (accept) mulPipe_q[0] <= mulResult;
        for (int i = 1; i < PIPE_N; i++) mulPipe_q[i] <= mulPipe_q[i-1];
      end
    end

    assign mulTail = mulPipe_q[PIPE_N-1];
  end else begin : gMulNoPipe
    assign mulTail = mulResult;
  end

  always_comb begin
    absA = (opSignedA(bus.req_op) && bus.req_a[XLEN-1]) ? -bus.req_a : bus.req_a;
    absB = (opSignedB(bus.req_op) && bus.req_b[XLEN-1]) ? -bus.req_b : bus.req_b;
  end

  // Divides whose answer is known from the operands alone complete without iterating
  always_comb begin
    divSpecial    = 1'b1;
    specialResult = '0;
    if (bus.req_b == '0) begin
      specialResult = bus.req_op[1] ? bus.req_a : '1;
    end else if (opSignedA(bus.req_op) && (bus.req_a == MIN_VAL) && (&bus.req_b)) begin
      specialResult = bus.req_op[1] ? '0 : MIN_VAL;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (absA < absB) begin
      specialResult = bus.req_op[1] ? bus.req_a : '0;
    end
`endif
    else begin
      divSpecial = 1'b0;
    end
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (divStart),
    .abort_i     (bus.flush),
    .dividend_i  (absA),
    .divisor_i   (absB),
    .done_o      (divDone),
    .quotient_o  (divQuo),
    .remainder_o (divRem)
  );

  always_comb begin
    signedDivQ = op_q[2] && !op_q[0];
    quoFixed   = (signedDivQ && (signA_q ^ signB_q)) ? -divQuo : divQuo;
    remFixed   = (signedDivQ && signA_q) ? -divRem : divRem;
    divResult  = op_q[1] ? remFixed : quoFixed;
  end

  always_comb begin
    state_d   = state_q;
    resData_d = resData_q;
    mulCnt_d  = mulCnt_q;
    divStart  = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!bus.req_op[2]) begin
              if (MUL_STAGES == 1) begin
                state_d   = DONE;
                resData_d = mulResult;
              end else begin
                state_d  = MUL;
                mulCnt_d = 3'(MUL_STAGES - 1);
              end
            end else if (divSpecial) begin
              state_d   = DONE;
              resData_d = specialResult;
            end else begin
              state_d  = DIV;
              divStart = 1'b1;
            end
          end
        end
        MUL: begin
          mulCnt_d = mulCnt_q - 3'd1;
          if (mulCnt_q == 3'd1) begin
            state_d   = DONE;
            resData_d = mulTail;
          end
        end
        DIV: begin
          if (divDone) begin
            state_d   = DONE;
            resData_d = divResult;
          end
        end
        DONE: begin
          if (bus.resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      resData_q <= '0;
      mulCnt_q  <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      resData_q <= resData_d;
      mulCnt_q  <= mulCnt_d;
      if (accept) begin
        op_q    <= bus.req_op;
        tag_q   <= bus.req_tag;
        signA_q <= bus.req_a[XLEN-1];
        signB_q <= bus.req_b[XLEN-1];
      end
    end
  end

  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = resData_q;
  assign bus.resp_tag   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=2); divide latencies
// follow MULDIV_EARLY_OUT_EN when the bench is built with it.
import muldiv_pkg::*;

module tb_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int MUL_STAGES = 2;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int L_DIV_NEG7_2 = 5;
  localparam int L_DIV_100_7  = 9;
  localparam int L_DIV_9_3    = 6;
`else
  localparam int L_DIV_NEG7_2 = 34;
  localparam int L_DIV_100_7  = 34;
  localparam int L_DIV_9_3    = 34;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nAsserts = 0;
  int   nFail    = 0;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge of cycle 1
  task automatic applyStimulus(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [TAG_W-1:0] tag);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitResp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic doOp(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [XLEN-1:0] expData, input int expLat);
    int lat;
    applyStimulus(op, a, b, tag);
    waitResp(lat);
    checkOutput({name, " data"}, bus.resp_data, expData);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " tag"}, bus.resp_tag, tag);
    handshake();
  endtask

  task automatic countStrayResp(input string name, input int cycles);
    int stray;
    stray = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.resp_valid) stray++;
    end
    checkOutput(name, stray, 0);
  endtask

  initial begin
    int lat;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset resp_valid", bus.resp_valid, 0);
    checkOutput("reset resp_data", bus.resp_data, 0);
    checkOutput("reset resp_tag", bus.resp_tag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", bus.req_ready, 1);

    $display("[TB] multiply by all-ones");
    doOp("MUL -1*-1",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 2);
    doOp("MULH -1*-1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 2);
    doOp("MULHU ff*ff",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 2);
    doOp("MULHSU -1*ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 2);

    $display("[TB] normal division");
    doOp("DIV -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, L_DIV_NEG7_2);
    doOp("REM -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, L_DIV_NEG7_2);
    doOp("DIVU 100/7", OP_DIVU, 32'd100,       32'd7, 5'd3, 32'd14,        L_DIV_100_7);
    doOp("REMU 100/7", OP_REMU, 32'd100,       32'd7, 5'd4, 32'd2,         L_DIV_100_7);
    doOp("DIVU 9/3",   OP_DIVU, 32'd9,         32'd3, 5'd5, 32'd3,         L_DIV_9_3);

    $display("[TB] divide by zero and signed overflow");
    doOp("DIV 5/0",     OP_DIV,  32'd5,         32'd0, 5'd6,  32'hFFFF_FFFF, 1);
    doOp("DIVU 5/0",    OP_DIVU, 32'd5,         32'd0, 5'd8,  32'hFFFF_FFFF, 1);
    doOp("REM 5/0",     OP_REM,  32'd5,         32'd0, 5'd10, 32'd5,         1);
    doOp("REMU min/0",  OP_REMU, 32'h8000_0000, 32'd0, 5'd12, 32'h8000_0000, 1);
    doOp("DIV min/-1",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    doOp("REM min/-1",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1);

    $display("[TB] response backpressure");
    applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd9);
    waitResp(lat);
    checkOutput("bp latency", lat, 2);
    bus.req_op    = OP_DIV;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd7;
    bus.req_tag   = 5'd30;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp resp_valid", bus.resp_valid, 1);
      checkOutput("bp resp_data", bus.resp_data, 12);
      checkOutput("bp resp_tag", bus.resp_tag, 9);
      checkOutput("bp req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1 checkOutput("bp req_ready in handshake", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    #1;
    checkOutput("bp req_ready after handshake", bus.req_ready, 1);
    checkOutput("bp resp_valid after handshake", bus.resp_valid, 0);
    countStrayResp("bp no accept during handshake", 4);

    $display("[TB] stray resp_ready while idle");
    handshake();
    #1;
    checkOutput("idle resp_ready req_ready", bus.req_ready, 1);
    checkOutput("idle resp_ready resp_valid", bus.resp_valid, 0);

    $display("[TB] flush of a divide in flight");
    @(negedge clk);
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd15);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    #1 checkOutput("flush masks req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checkOutput("flush resp_valid", bus.resp_valid, 0);
    checkOutput("flush req_ready next", bus.req_ready, 1);
    countStrayResp("flushed div response", 40);

    $display("[TB] flush together with a request");
    bus.req_op    = OP_MUL;
    bus.req_a     = 32'd6;
    bus.req_b     = 32'd7;
    bus.req_tag   = 5'd16;
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    #1 checkOutput("flush+req req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    countStrayResp("flush+req not accepted", 4);
    doOp("MUL 6*7 after flush", OP_MUL, 32'd6, 32'd7, 5'd11, 32'd42, 2);

    $display("[TB] flush of a held result");
    applyStimulus(OP_MUL, 32'd2, 32'd2, 5'd17);
    waitResp(lat);
    checkOutput("held result valid", bus.resp_valid, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checkOutput("held result discarded", bus.resp_valid, 0);
    checkOutput("held result req_ready", bus.req_ready, 1);
    countStrayResp("held result stays discarded", 4);

    $display("[TB] reset during a divide");
    @(negedge clk);
    applyStimulus(OP_DIV, 32'd1000, 32'd3, 5'd21);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset resp_valid", bus.resp_valid, 0);
    checkOutput("midreset resp_data", bus.resp_data, 0);
    checkOutput("midreset resp_tag", bus.resp_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("midreset req_ready", bus.req_ready, 1);
    countStrayResp("midreset no response", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
